msf_bit_decoder: RTL and testbench

- Downstream stage of the IQ averager. Consumes one signed averaged carrier amplitude per 100 ms slot, together with its valid strobe and a second-alignment sync.
- Slices each slot into carrier-on or carrier-off using hysteresis thresholds.
- Collects 10 slots per second and classifies the on/off pattern into MSF bits A/B, the minute marker, or an error.
- Results feed the time-frame assembler over a single-cycle strobe.

---
 rtl/msf_bit_decoder_if.sv | 28 ++
 rtl/msf_bit_decoder.sv | 124 ++++++++++++
 tb/tb_msf_bit_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/msf_bit_decoder_if.sv
// Bundle between the IQ averager and the MSF bit decoder.
// master: drives the averaged amplitude, its strobes and the slicer thresholds, and receives the decoded bits.
// slave: the decoder side of the same signals.
interface msf_bit_decoder_if #(
  parameter int NBITS = 16
);
  logic signed [NBITS-1:0] average;
  logic                    avg_valid;
  logic                    sec_sync;
  logic        [NBITS-2:0] thr_hi;
  logic        [NBITS-2:0] thr_lo;
  logic                    bit_a;
  logic                    bit_b;
  logic                    minute_mark;
  logic                    sym_err;
  logic                    bit_valid;
  logic                    locked;

  modport master (
    output average, avg_valid, sec_sync, thr_hi, thr_lo,
    input  bit_a, bit_b, minute_mark, sym_err, bit_valid, locked
  );

  modport slave (
    input  average, avg_valid, sec_sync, thr_hi, thr_lo,
    output bit_a, bit_b, minute_mark, sym_err, bit_valid, locked
  );
endinterface

// File: rtl/msf_bit_decoder.sv
// MSF bit decoder: slices each 100 ms amplitude slot on/off with hysteresis, then classifies 10 slots into A/B bits, minute marker or error.
// Ports: clk, rst_n (async active-low), bus (slave): average/avg_valid/sec_sync/thr_hi/thr_lo in;
//        bit_a/bit_b/minute_mark/sym_err/bit_valid out (1-cycle latency after slot 9 or a short-second sync), locked out.
module msf_bit_decoder #(
  parameter int NBITS = 16,
  parameter int SLOTS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  msf_bit_decoder_if.slave   bus
);

  localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);

  // Slot patterns, bit i = slot i, 1 = carrier on.
  localparam logic [9:0] PAT_MINUTE = 10'b11111_00000;
  localparam logic [9:0] PAT_A0_B0  = 10'b11111_11110;
  localparam logic [9:0] PAT_A1_B0  = 10'b11111_11100;
  localparam logic [9:0] PAT_A1_B1  = 10'b11111_11000;
  localparam logic [9:0] PAT_A0_B1  = 10'b11111_11010;

  logic             car_on;
  logic [SLOTS-1:0] pattern;
  logic [3:0]       slot_cnt;
  logic             lock_reg;
  logic             short_flag;

  logic [NBITS-1:0] neg_avg;
  logic [NBITS-2:0] mag;
  logic             car_next;
  logic [3:0]       slot;
  logic [SLOTS-1:0] pat_next;
  logic             is_short;
  logic             is_last;
  logic             cls_a, cls_b, cls_mm, cls_err;

  assign neg_avg = -bus.average;

  always_comb begin
    // The most negative input has no positive twin; clamp it to full scale.
    if (bus.average[NBITS-1] && (bus.average[NBITS-2:0] == '0))
      mag = '1;
    else if (bus.average[NBITS-1])
      mag = neg_avg[NBITS-2:0];
    else
      mag = bus.average[NBITS-2:0];
  end

  always_comb begin
    // thr_hi wins so swapped thresholds still give a defined result.
    car_next = car_on;
    if (mag > bus.thr_hi)
      car_next = 1'b1;
    else if (mag < bus.thr_lo)
      car_next = 1'b0;
  end

  always_comb begin
    slot           = bus.sec_sync ? 4'd0 : slot_cnt;
    pat_next       = pattern;
    pat_next[slot] = car_next;
    is_short       = bus.avg_valid && bus.sec_sync && (slot_cnt != 4'd0);
    is_last        = bus.avg_valid && (slot == LAST_SLOT);
  end

  always_comb begin
    cls_a   = 1'b0;
    cls_b   = 1'b0;
    cls_mm  = 1'b0;
    cls_err = 1'b0;
    case (pat_next)
      PAT_MINUTE: begin cls_mm = 1'b1; cls_a = 1'b1; cls_b = 1'b1; end
      PAT_A0_B0:  ;
      PAT_A1_B0:  cls_a = 1'b1;
      PAT_A1_B1:  begin cls_a = 1'b1; cls_b = 1'b1; end
      PAT_A0_B1:  cls_b = 1'b1;
      default:    cls_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_on          <= 1'b1;
      pattern         <= '1;
      slot_cnt        <= 4'd0;
      lock_reg        <= 1'b0;
      short_flag      <= 1'b0;
      bus.bit_a       <= 1'b0;
      bus.bit_b       <= 1'b0;
      bus.minute_mark <= 1'b0;
      bus.sym_err     <= 1'b0;
      bus.bit_valid   <= 1'b0;
    end else begin
      bus.bit_valid <= 1'b0;
      short_flag    <= 1'b0;
      if (bus.avg_valid) begin
        car_on   <= car_next;
        pattern  <= pat_next;
        slot_cnt <= (slot == LAST_SLOT) ? 4'd0 : 4'(slot + 4'd1);
        if (slot == 4'd0)
          lock_reg <= bus.sec_sync;
        if (is_short) begin
          // The sync sample still opens the new second; only the report is an error.
          bus.bit_valid   <= 1'b1;
          bus.sym_err     <= 1'b1;
          bus.bit_a       <= 1'b0;
          bus.bit_b       <= 1'b0;
          bus.minute_mark <= 1'b0;
          short_flag      <= 1'b1;
        end else if (is_last) begin
          bus.bit_valid   <= 1'b1;
          bus.sym_err     <= cls_err;
          bus.bit_a       <= cls_a;
          bus.bit_b       <= cls_b;
          bus.minute_mark <= cls_mm;
        end
      end
    end
  end

  // lock_reg already tracks the new synced second; the short-second report itself shows unlocked.
  assign bus.locked = lock_reg && !short_flag;

endmodule

// File: tb/tb_msf_bit_decoder.sv
module tb_msf_bit_decoder;

  logic clk = 1'b0;
  logic rst_n;

  msf_bit_decoder_if #(.NBITS(16)) bus ();

  msf_bit_decoder #(.NBITS(16), .SLOTS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state: on/off list of the current second plus expected outputs.
  bit cur[$];
  bit car;
  bit sec_synced;
  bit short_now;
  bit exp_bv, exp_a, exp_b, exp_mm, exp_err, exp_lk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [5:0] dut_vec();
    return {bus.bit_valid, bus.bit_a, bus.bit_b, bus.minute_mark, bus.sym_err, bus.locked};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {exp_bv, exp_a, exp_b, exp_mm, exp_err, exp_lk};
  endfunction

  task automatic model_reset();
    car = 1'b1;
    cur.delete();
    sec_synced = 1'b0;
    {exp_bv, exp_a, exp_b, exp_mm, exp_err, exp_lk} = 6'b0;
  endtask

  task automatic classify();
    int  k;
    bit  rest_on;
    k = 0;
    while (k < 10 && cur[k] == 1'b0) k++;
    rest_on = 1'b1;
    for (int i = k; i < 10; i++) if (!cur[i]) rest_on = 1'b0;
    {exp_a, exp_b, exp_mm, exp_err} = 4'b0001;
    if (k == 5 && rest_on)
      {exp_a, exp_b, exp_mm, exp_err} = 4'b1110;
    else if (k >= 1 && k <= 3 && rest_on)
      {exp_a, exp_b, exp_mm, exp_err} = {(k >= 2), (k == 3), 2'b00};
    else if (k == 1 && cur[1] && !cur[2]) begin
      rest_on = 1'b1;
      for (int i = 3; i < 10; i++) if (!cur[i]) rest_on = 1'b0;
      if (rest_on) {exp_a, exp_b, exp_mm, exp_err} = 4'b0100;
    end
    exp_bv = 1'b1;
  endtask

  task automatic model_sample(input int amp, input bit sync);
    int m;
    m = (amp < 0) ? -amp : amp;
    if (m > 32767) m = 32767;
    if (m > int'(bus.thr_hi)) car = 1'b1;
    else if (m < int'(bus.thr_lo)) car = 1'b0;
    if (sync) begin
      if (cur.size() != 0) begin
        short_now = 1'b1;
        exp_bv = 1'b1;
        {exp_a, exp_b, exp_mm, exp_err} = 4'b0001;
      end
      cur.delete();
      sec_synced = 1'b1;
    end else if (cur.size() == 0) begin
      sec_synced = 1'b0;
    end
    cur.push_back(car);
    if (cur.size() == 10) begin
      classify();
      cur.delete();
    end
  endtask

  // One clock cycle of stimulus; the model advances on the same edge as the DUT.
  task automatic cycle(input bit v, input int amp, input bit sync);
    bus.avg_valid = v;
    bus.average   = 16'(amp);
    bus.sec_sync  = sync;
    @(posedge clk);
    exp_bv    = 1'b0;
    short_now = 1'b0;
    if (v) model_sample(amp, sync);
    exp_lk = short_now ? 1'b0 : sec_synced;
    @(negedge clk);
  endtask

  task automatic send(input int amp, input bit sync);
    cycle(1'b1, amp, sync);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 1'b0);
  endtask

  // Pins both the DUT and the model to a hand-derived {bv,a,b,mm,err,locked}.
  task automatic pin(input string name, input logic [5:0] req);
    chk({name, " dut"}, 32'(dut_vec()), 32'(req));
    chk({name, " model"}, 32'(exp_vec()), 32'(req));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("bit_valid",   32'(bus.bit_valid),   32'(exp_bv));
        chk("locked",      32'(bus.locked),      32'(exp_lk));
        chk("bit_a",       32'(bus.bit_a),       32'(exp_a));
        chk("bit_b",       32'(bus.bit_b),       32'(exp_b));
        chk("minute_mark", 32'(bus.minute_mark), 32'(exp_mm));
        chk("sym_err",     32'(bus.sym_err),     32'(exp_err));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.avg_valid = 1'b0;
    bus.sec_sync  = 1'b0;
    bus.average   = '0;
    bus.thr_hi    = 15'd1000;
    bus.thr_lo    = 15'd600;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'(dut_vec()), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle();

    // A=1 B=0: two off slots.
    send(50, 1'b1);
    send(50, 1'b0);
    repeat (8) send(2000, 1'b0);
    pin("t1 A1B0", 6'b110001);
    idle();
    idle();

    // Slot 0 on from a negative amplitude -> error; then A=0 B=1 back to back.
    send(-3000, 1'b1);
    repeat (9) send(2000, 1'b0);
    pin("t2 err", 6'b100011);
    send(100, 1'b1);
    send(2000, 1'b0);
    send(100, 1'b0);
    repeat (7) send(2000, 1'b0);
    pin("t2 A0B1", 6'b101001);
    idle();

    // Minute marker, then again with a mid-band sample held off by hysteresis.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++)
        send((i >= 5) ? 2000 : ((r == 1 && i == 3) ? 800 : 100), (i == 0));
      pin((r == 0) ? "t3 minute" : "t3 minute hyst", 6'b111101);
      idle();
    end

    // Short second: sync after 4 samples.
    send(2000, 1'b1);
    repeat (3) send(2000, 1'b0);
    send(100, 1'b1);
    pin("t4 short", 6'b100010);
    repeat (9) send(2000, 1'b0);
    pin("t4 A0B0 relocked", 6'b100001);
    idle();

    // Most negative input saturates to on.
    send(100, 1'b1);
    repeat (4) send(2000, 1'b0);
    send(-32768, 1'b0);
    repeat (4) send(2000, 1'b0);
    pin("t5 saturate", 6'b100001);
    idle();

    // Reset at slot 6 of a second.
    send(100, 1'b1);
    repeat (5) send(2000, 1'b0);
    bus.avg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5 async reset", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    send(100, 1'b0);
    repeat (8) send(2000, 1'b0);
    pin("t5 no early strobe", 6'b000000);
    send(2000, 1'b0);
    pin("t5 free-running", 6'b100000);
    idle();
    idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
